router_pkt_tx: RTL and testbench

Upstream packet source for the three-port router. It accepts a send command (destination, payload length) and the payload bytes from a host-side valid/ready stream, and buffers the whole payload internally. It then emits one router-format packet on the router input: a header byte, the payload bytes, and a parity byte. The router's busy signal throttles every byte. Its outputs drive the router's pkt_valid and data_in directly; busy is taken from the router.

---
 rtl/router_pkt_tx.sv | 133 +++++++++++++
 tb/tb_router_pkt_tx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_tx.sv
// Host-side packet source for the three-port router: buffers a whole payload,
// then emits header, payload and XOR parity under router busy throttling.
module router_pkt_tx #(
   parameter int NUM_PORTS = 3,
   parameter int MAX_LEN   = 63
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       start,
   input  logic [1:0] dest_addr,
   input  logic [5:0] pay_len,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   input  logic       busy,
   output logic       pkt_valid,
   output logic [7:0] data_out,
   output logic       tx_active,
   output logic       done,
   output logic       cmd_err
);

   typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, DONE} state_t;

   typedef struct packed {
      logic       tx_ready;
      logic       pkt_valid;
      logic [7:0] data_out;
      logic       tx_active;
      logic       done;
      logic       cmd_err;
   } out_t;

   state_t     state, state_nxt;
   logic [5:0] cnt, cnt_nxt;
   logic [5:0] len, len_nxt;
   logic [1:0] addr, addr_nxt;
   logic [7:0] par, par_nxt;
   logic       wr_en;
   out_t       out_q, out_nxt;

   logic [7:0] mem [MAX_LEN];

   wire cmd_ok = (dest_addr != 2'd3) && (int'(dest_addr) < NUM_PORTS) && (pay_len != 6'd0);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      len_nxt   = len;
      addr_nxt  = addr;
      par_nxt   = par;
      wr_en     = 1'b0;
      out_nxt   = '0;
      case (state)
         IDLE: if (start) begin
            if (cmd_ok) begin
               len_nxt   = pay_len;
               addr_nxt  = dest_addr;
               cnt_nxt   = 6'd0;
               par_nxt   = {pay_len, dest_addr};
               state_nxt = LOAD;
            end else begin
               out_nxt.cmd_err = 1'b1;
            end
         end
         LOAD: if (tx_valid) begin
            wr_en   = 1'b1;
            par_nxt = par ^ tx_data;
            if (cnt == len - 6'd1) begin
               cnt_nxt   = 6'd0;
               state_nxt = HEADER;
            end else begin
               cnt_nxt = cnt + 6'd1;
            end
         end
         HEADER: if (!busy) state_nxt = PAYLOAD;
         PAYLOAD: if (!busy) begin
            if (cnt == len - 6'd1) begin
               cnt_nxt   = 6'd0;
               state_nxt = PARITY;
            end else begin
               cnt_nxt = cnt + 6'd1;
            end
         end
         PARITY: if (!busy) state_nxt = DONE;
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase

      // Outputs are decoded from the next state so every port comes straight off a flop.
      out_nxt.tx_ready  = (state_nxt == LOAD);
      out_nxt.pkt_valid = (state_nxt == HEADER) || (state_nxt == PAYLOAD);
      out_nxt.tx_active = (state_nxt != IDLE);
      out_nxt.done      = (state_nxt == DONE);
      case (state_nxt)
         HEADER:  out_nxt.data_out = {len_nxt, addr_nxt};
         PAYLOAD: out_nxt.data_out = mem[cnt_nxt];
         PARITY:  out_nxt.data_out = par_nxt;
         default: out_nxt.data_out = 8'd0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= 6'd0;
         len   <= 6'd0;
         addr  <= 2'd0;
         par   <= 8'd0;
         out_q <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         len   <= len_nxt;
         addr  <= addr_nxt;
         par   <= par_nxt;
         out_q <= out_nxt;
      end
   end

   // Buffer contents are don't-care after reset, so no reset term here.
   always_ff @(posedge clock) begin
      if (wr_en) mem[cnt] <= tx_data;
   end

   assign tx_ready  = out_q.tx_ready;
   assign pkt_valid = out_q.pkt_valid;
   assign data_out  = out_q.data_out;
   assign tx_active = out_q.tx_active;
   assign done      = out_q.done;
   assign cmd_err   = out_q.cmd_err;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Randomized bench for router_pkt_tx: each packet's expected byte stream is
// built from the packet format (header, payload, XOR parity) and compared per cycle.
module tb_router_pkt_tx;

   logic       clock = 1'b0;
   logic       resetn;
   logic       start;
   logic [1:0] dest_addr;
   logic [5:0] pay_len;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;
   logic       busy;
   logic       pkt_valid;
   logic [7:0] data_out;
   logic       tx_active;
   logic       done;
   logic       cmd_err;

   int n_vec = 0;
   int n_err = 0;
   logic [7:0] pay [64];

   router_pkt_tx #(.NUM_PORTS(3), .MAX_LEN(63)) dut (
      .clock(clock), .resetn(resetn), .start(start), .dest_addr(dest_addr),
      .pay_len(pay_len), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .busy(busy), .pkt_valid(pkt_valid), .data_out(data_out), .tx_active(tx_active),
      .done(done), .cmd_err(cmd_err)
   );

   always #5 clock = ~clock;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic test_reset();
      resetn = 1'b0; start = 1'b1; dest_addr = 2'd1; pay_len = 6'd4;
      tx_valid = 1'b1; tx_data = 8'hAA; busy = 1'b0;
      repeat (3) @(negedge clock);
      n_vec++; if (tx_ready  !== 1'b0) begin n_err++; $display("FAIL rst_tx_ready got %b exp 0", tx_ready); end
      n_vec++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL rst_pkt_valid got %b exp 0", pkt_valid); end
      n_vec++; if (data_out  !== 8'h00) begin n_err++; $display("FAIL rst_data_out got %h exp 00", data_out); end
      n_vec++; if (tx_active !== 1'b0) begin n_err++; $display("FAIL rst_tx_active got %b exp 0", tx_active); end
      n_vec++; if (done      !== 1'b0) begin n_err++; $display("FAIL rst_done got %b exp 0", done); end
      n_vec++; if (cmd_err   !== 1'b0) begin n_err++; $display("FAIL rst_cmd_err got %b exp 0", cmd_err); end
      start = 1'b0; tx_valid = 1'b0; resetn = 1'b1;
      @(negedge clock);
      n_vec++; if (tx_active !== 1'b0) begin n_err++; $display("FAIL rst_idle got %b exp 0", tx_active); end
   endtask

   // vmode: 0 held, 1 every other cycle, 2 random.  bmode: 0 none, 1 random, 2 one stall on first payload byte.
   task automatic run_pkt(input logic [1:0] a, input logic [5:0] l, input int vmode,
                          input int bmode, input int abort_idx);
      logic [7:0] exp_b[$];
      bit         exp_v[$];
      logic [7:0] p;
      int n, k, idx, cyc, stalls;
      bit v, b;
      n = int'(l);
      p = {l, a};
      exp_b = {}; exp_v = {};
      exp_b.push_back(p); exp_v.push_back(1'b1);
      for (int i = 0; i < n; i++) begin
         exp_b.push_back(pay[i]); exp_v.push_back(1'b1);
         p = p ^ pay[i];
      end
      exp_b.push_back(p); exp_v.push_back(1'b0);

      @(negedge clock);
      start = 1'b1; dest_addr = a; pay_len = l;
      @(negedge clock);
      start = 1'b0;
      n_vec++; if (tx_active !== 1'b1) begin n_err++; $display("FAIL cmd_accept got %b exp 1", tx_active); end

      k = 0;
      for (cyc = 0; cyc < 2000 && k < n; cyc++) begin
         n_vec++; if (tx_ready !== 1'b1) begin n_err++; $display("FAIL load_ready k=%0d got %b exp 1", k, tx_ready); end
         n_vec++; if (cmd_err !== 1'b0) begin n_err++; $display("FAIL load_cmd_err got %b exp 0", cmd_err); end
         case (vmode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = ($urandom_range(0, 1) == 1);
         endcase
         tx_valid = v;
         tx_data  = v ? pay[k] : 8'($urandom);
         start    = ($urandom_range(0, 1) == 1);
         dest_addr = 2'd3; pay_len = 6'd0;
         @(negedge clock);
         if (v) k++;
      end
      tx_valid = 1'b0; start = 1'b0;
      n_vec++; if (k != n) begin n_err++; $display("FAIL load_timeout writes %0d exp %0d", k, n); end
      n_vec++; if (tx_ready !== 1'b0) begin n_err++; $display("FAIL ready_drop got %b exp 0", tx_ready); end

      idx = 0; stalls = 0;
      for (cyc = 0; cyc < 4000 && idx < n + 2; cyc++) begin
         n_vec++; if (data_out !== exp_b[idx]) begin n_err++; $display("FAIL byte idx=%0d got %h exp %h", idx, data_out, exp_b[idx]); end
         n_vec++; if (pkt_valid !== exp_v[idx]) begin n_err++; $display("FAIL pkt_valid idx=%0d got %b exp %b", idx, pkt_valid, exp_v[idx]); end
         n_vec++; if (tx_active !== 1'b1 || done !== 1'b0) begin n_err++; $display("FAIL tx_state idx=%0d active %b done %b exp 1 0", idx, tx_active, done); end
         if (idx == abort_idx) begin
            resetn = 1'b0; busy = 1'b0;
            @(negedge clock);
            n_vec++; if (pkt_valid !== 1'b0) begin n_err++; $display("FAIL abort_pkt_valid got %b exp 0", pkt_valid); end
            n_vec++; if (tx_active !== 1'b0) begin n_err++; $display("FAIL abort_tx_active got %b exp 0", tx_active); end
            n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL abort_done got %b exp 0", done); end
            n_vec++; if (data_out !== 8'h00) begin n_err++; $display("FAIL abort_data got %h exp 00", data_out); end
            resetn = 1'b1;
            @(negedge clock);
            n_vec++; if (done !== 1'b0 || tx_active !== 1'b0) begin n_err++; $display("FAIL abort_after done %b active %b exp 0 0", done, tx_active); end
            return;
         end
         case (bmode)
            0:       b = 1'b0;
            1:       b = ($urandom_range(0, 3) == 0);
            default: b = (idx == 1 && stalls == 0);
         endcase
         busy = b;
         @(negedge clock);
         if (b) stalls++; else idx++;
      end
      busy = 1'b0;
      n_vec++; if (idx != n + 2) begin n_err++; $display("FAIL tx_timeout bytes %0d exp %0d", idx, n + 2); end
      n_vec++; if (cyc != n + 2 + stalls) begin n_err++; $display("FAIL hdr_to_done cycles %0d exp %0d", cyc, n + 2 + stalls); end
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL done_pulse got %b exp 1", done); end
      n_vec++; if (pkt_valid !== 1'b0 || data_out !== 8'h00) begin n_err++; $display("FAIL done_outs valid %b data %h exp 0 00", pkt_valid, data_out); end
      start = 1'b1; dest_addr = 2'($urandom_range(0, 3)); pay_len = 6'($urandom_range(0, 63));
      @(negedge clock);
      start = 1'b0;
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL done_width got %b exp 0", done); end
      n_vec++; if (tx_active !== 1'b0 || tx_ready !== 1'b0) begin n_err++; $display("FAIL start_in_done active %b ready %b exp 0 0", tx_active, tx_ready); end
      n_vec++; if (cmd_err !== 1'b0) begin n_err++; $display("FAIL start_in_done_err got %b exp 0", cmd_err); end
   endtask

   task automatic test_basic();
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
      run_pkt(2'd1, 6'd4, 0, 0, -1);
   endtask

   task automatic test_busy_stall();
      pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33; pay[3] = 8'h44;
      run_pkt(2'd1, 6'd4, 0, 2, -1);
   endtask

   task automatic test_cmd_err(input logic [1:0] a, input logic [5:0] l);
      @(negedge clock);
      start = 1'b1; dest_addr = a; pay_len = l; tx_valid = 1'b1;
      @(negedge clock);
      start = 1'b0;
      n_vec++; if (cmd_err !== 1'b1) begin n_err++; $display("FAIL cmd_err a=%0d l=%0d got %b exp 1", a, l, cmd_err); end
      n_vec++; if (tx_ready !== 1'b0 || tx_active !== 1'b0) begin n_err++; $display("FAIL cmd_err_idle ready %b active %b exp 0 0", tx_ready, tx_active); end
      @(negedge clock);
      tx_valid = 1'b0;
      n_vec++; if (cmd_err !== 1'b0) begin n_err++; $display("FAIL cmd_err_width got %b exp 0", cmd_err); end
      n_vec++; if (tx_ready !== 1'b0 || tx_active !== 1'b0) begin n_err++; $display("FAIL cmd_err_stay ready %b active %b exp 0 0", tx_ready, tx_active); end
   endtask

   task automatic test_max_len();
      for (int i = 0; i < 63; i++) pay[i] = 8'($urandom);
      run_pkt(2'd0, 6'd63, 1, 0, -1);
   endtask

   task automatic test_reset_abort();
      for (int i = 0; i < 10; i++) pay[i] = 8'($urandom);
      run_pkt(2'd2, 6'd10, 0, 0, 3);
      for (int i = 0; i < 7; i++) pay[i] = 8'($urandom);
      run_pkt(2'd1, 6'd7, 0, 1, -1);
   endtask

   task automatic test_random();
      logic [1:0] a;
      logic [5:0] l;
      for (int t = 0; t < 20; t++) begin
         a = 2'($urandom_range(0, 2));
         l = 6'($urandom_range(1, 63));
         for (int i = 0; i < 63; i++) pay[i] = 8'($urandom);
         run_pkt(a, l, 2, 1, -1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_busy_stall();
      test_cmd_err(2'd3, 6'd5);
      test_cmd_err(2'd0, 6'd0);
      test_max_len();
      test_reset_abort();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
